sao_decision_ctrl: RTL

- Sequences the SAO type-decision datapath for one CTB. Runs it once per enabled colour component (Y, U, V).
- Drives mode_cnt/data_valid/bo_predecision into the decision unit and stalls on the statistics/offset engine.
- Captures the winning type/sub-type/offset per component and emits one parameter beat per component to the SAO parameter/entropy stage.

---
 rtl/sao_decision_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/sao_decision_ctrl.sv
// ---------------------------------------------------------------------------
// sao_decision_ctrl
// Sequences the SAO type-decision datapath for one CTB. For every enabled
// colour component (Y, U, V, lowest index first) it clears the decision unit,
// walks mode_cnt from 1 to LAST_MODE (stalling on the statistics engine),
// captures the winning type/sub-type/offset and emits one parameter beat.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start_i               start pulse (accepted only when idle)
//   comp_en_i[2:0]        per-component enable, bit0 = Y (sampled on start)
//   bo_band_i[14:0]       packed 5-bit BO bands, [4:0] = Y (sampled on start)
//   stat_ready_i          statistics/offset engine ready for current mode_cnt
//   dec_type_i/dec_sub_type_i/dec_offset_i   decision unit result
//   mode_cnt_o, data_valid_o, bo_predecision_o, comp_idx_o   to decision unit
//   busy_o, done_o        run status / CTB-finished pulse
//   param_*_o             per-component parameter beat (valid pulses, rest hold)
// ---------------------------------------------------------------------------
module sao_decision_ctrl #(
  parameter int NUM_COMP     = 3,
  parameter int LAST_MODE    = 23,
  parameter int BO_MAX_START = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [2:0]  comp_en_i,
  input  logic [14:0] bo_band_i,
  input  logic        stat_ready_i,
  input  logic [2:0]  dec_type_i,
  input  logic [4:0]  dec_sub_type_i,
  input  logic [11:0] dec_offset_i,
  output logic [4:0]  mode_cnt_o,
  output logic        data_valid_o,
  output logic [4:0]  bo_predecision_o,
  output logic [1:0]  comp_idx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        param_valid_o,
  output logic [1:0]  param_comp_o,
  output logic        param_on_o,
  output logic [2:0]  param_type_o,
  output logic [4:0]  param_sub_type_o,
  output logic [11:0] param_offset_o
);

  localparam logic [4:0] LAST_M  = 5'(LAST_MODE);
  localparam logic [4:0] HOLD_M  = 5'(LAST_MODE + 1);  // post-run value, never 0
  localparam logic [4:0] BO_MAX  = 5'(BO_MAX_START);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_WAIT, S_OUT} state_t;

  state_t      state_q, state_d;
  logic [4:0]  mode_q, mode_d;
  logic [1:0]  comp_q, comp_d;
  logic [2:0]  en_q, en_d;
  logic [14:0] band_q, band_d;
  logic [4:0]  bo_q, bo_d;
  logic        done_q, done_d;
  logic        pv_q, pv_d;
  logic [1:0]  pcomp_q, pcomp_d;
  logic        pon_q, pon_d;
  logic [2:0]  ptype_q, ptype_d;
  logic [4:0]  psub_q, psub_d;
  logic [11:0] poff_q, poff_d;

  // {found, idx}: lowest enabled component with index >= from
  function automatic logic [2:0] pick(input logic [2:0] mask, input logic [1:0] from);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_COMP - 1; i >= 0; i--)
      if (mask[i] && i >= int'(from)) r = {1'b1, 2'(i)};
    return r;
  endfunction

  // BO start band for a component, clamped so start+4 stays in range
  function automatic logic [4:0] bo_for(input logic [14:0] bands, input logic [1:0] idx);
    logic [4:0] b;
    case (idx)
      2'd0:    b = bands[4:0];
      2'd1:    b = bands[9:5];
      default: b = bands[14:10];
    endcase
    return (b > BO_MAX) ? BO_MAX : b;
  endfunction

  logic [2:0] first_c, next_c;
  assign first_c = pick(comp_en_i, 2'd0);
  assign next_c  = pick(en_q, comp_q + 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      comp_q  <= '0;
      en_q    <= '0;
      band_q  <= '0;
      bo_q    <= '0;
      done_q  <= 1'b0;
      pv_q    <= 1'b0;
      pcomp_q <= '0;
      pon_q   <= 1'b0;
      ptype_q <= '0;
      psub_q  <= '0;
      poff_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      comp_q  <= comp_d;
      en_q    <= en_d;
      band_q  <= band_d;
      bo_q    <= bo_d;
      done_q  <= done_d;
      pv_q    <= pv_d;
      pcomp_q <= pcomp_d;
      pon_q   <= pon_d;
      ptype_q <= ptype_d;
      psub_q  <= psub_d;
      poff_q  <= poff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    comp_d  = comp_q;
    en_d    = en_q;
    band_d  = band_q;
    bo_d    = bo_q;
    done_d  = 1'b0;
    pv_d    = 1'b0;
    pcomp_d = pcomp_q;
    pon_d   = pon_q;
    ptype_d = ptype_q;
    psub_d  = psub_q;
    poff_d  = poff_q;
    case (state_q)
      S_IDLE: begin
        mode_d = '0;
        if (start_i) begin
          en_d   = comp_en_i;
          band_d = bo_band_i;
          if (first_c[2]) begin
            state_d = S_CLR;
            comp_d  = first_c[1:0];
            bo_d    = bo_for(bo_band_i, first_c[1:0]);
          end else begin
            done_d = 1'b1;  // nothing enabled: finish immediately
          end
        end
      end
      S_CLR: begin
        state_d = S_RUN;
        mode_d  = 5'd1;
      end
      S_RUN: begin
        if (stat_ready_i) begin
          if (mode_q == LAST_M) begin
            state_d = S_WAIT;
            mode_d  = HOLD_M;
          end else begin
            mode_d = mode_q + 5'd1;
          end
        end
      end
      S_WAIT: begin
        // decision outputs are final here; register them for the OUT beat
        state_d = S_OUT;
        pv_d    = 1'b1;
        pcomp_d = comp_q;
        pon_d   = (dec_offset_i != '0);
        ptype_d = dec_type_i;
        psub_d  = dec_sub_type_i;
        poff_d  = dec_offset_i;
        done_d  = ~next_c[2];  // lands in the OUT cycle of the last component
      end
      S_OUT: begin
        mode_d = '0;
        if (next_c[2]) begin
          state_d = S_CLR;
          comp_d  = next_c[1:0];
          bo_d    = bo_for(band_q, next_c[1:0]);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mode_cnt_o       = mode_q;
  assign data_valid_o     = (state_q == S_RUN) && stat_ready_i &&
                            (mode_q inside {5'd3, 5'd7, 5'd11, 5'd15, 5'd19,
                                            5'd20, 5'd21, 5'd22, 5'd23});
  assign bo_predecision_o = bo_q;
  assign comp_idx_o       = comp_q;
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = done_q;
  assign param_valid_o    = pv_q;
  assign param_comp_o     = pcomp_q;
  assign param_on_o       = pon_q;
  assign param_type_o     = ptype_q;
  assign param_sub_type_o = psub_q;
  assign param_offset_o   = poff_q;

endmodule
